// File: rtl/i2c_cmd_arbiter_pkg.sv
// Shared types and constants for the I2C command arbiter slice.
package i2c_cfg_pkg;

  localparam int I2C_WORD_W = 24;

  // Common slave addresses on the DE2 board
  localparam logic [7:0] AUDIO_ADDR = 8'h34;
  localparam logic [7:0] VIDEO_ADDR = 8'h40;

  // Controller ACK status: low means every byte was acknowledged
  localparam logic ACK_OK = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    FAIL,
    GAP,
    RESP_OK,
    RESP_ERR
  } arbState_t;

endpackage

// File: rtl/i2c_cmd_arbiter_if.sv
// Requester and controller-side signal bundle of the I2C command arbiter.
interface i2c_cmd_arbiter_if
  import i2c_cfg_pkg::*;
#(
  parameter int NUM_REQ = 3
) ();

  logic [NUM_REQ-1:0]            iREQ;
  logic [I2C_WORD_W*NUM_REQ-1:0] iDATA;
  logic [NUM_REQ-1:0]            oGNT;
  logic [NUM_REQ-1:0]            oDONE;
  logic [NUM_REQ-1:0]            oERR;
  logic                          oBUSY;
  logic                          oI2C_CLK;
  logic [I2C_WORD_W-1:0]         oI2C_DATA;
  logic                          oI2C_GO;
  logic                          iI2C_END;
  logic                          iI2C_ACK;

  // Arbiter side
  modport master (
    input  iREQ, iDATA, iI2C_END, iI2C_ACK,
    output oGNT, oDONE, oERR, oBUSY, oI2C_CLK, oI2C_DATA, oI2C_GO
  );

  // Requesters plus controller side
  modport slave (
    output iREQ, iDATA, iI2C_END, iI2C_ACK,
    input  oGNT, oDONE, oERR, oBUSY, oI2C_CLK, oI2C_DATA, oI2C_GO
  );

endinterface

// File: rtl/i2c_cmd_arbiter_tick_gen.sv
// Controller work-clock divider; flags the iCLK cycle in which the work clock rises.
module i2c_tick_gen #(
  parameter int CLK_DIV = 1250
) (
  input  logic iCLK,
  input  logic iRST,
  output logic oI2C_CLK,
  output logic oTick
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] divCnt;
  logic             divWrap;

  assign divWrap = (divCnt == DIV_W'(CLK_DIV - 1));
  assign oTick   = divWrap & ~oI2C_CLK;

  // Half-period counter; work clock toggles on every wrap
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      divCnt   <= '0;
      oI2C_CLK <= 1'b0;
    end else if (divWrap) begin
      divCnt   <= '0;
      oI2C_CLK <= ~oI2C_CLK;
    end else begin
      divCnt   <= divCnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2c_cmd_arbiter.sv
// Round-robin sharing of one byte-level I2C write controller among NUM_REQ requesters,
// with GO/END sequencing, retry on NACK or timeout, and per-requester done/err pulses.
module i2c_cmd_arbiter
  import i2c_cfg_pkg::*;
#(
  parameter int NUM_REQ   = 3,
  parameter int CLK_DIV   = 1250,
  parameter int MAX_RETRY = 3,
  parameter int RETRY_GAP = 4,
  parameter int TIMEOUT   = 64
) (
  input  logic               iCLK,
  input  logic               iRST,
  i2c_cmd_arbiter_if.master  bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int ATT_W = 4;
  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam int GAP_W = (RETRY_GAP > 1) ? $clog2(RETRY_GAP + 1) : 1;

  arbState_t             state, stateNext;
  logic [IDX_W-1:0]      rrPtr, rrPtrNext;
  logic [IDX_W-1:0]      owner, ownerNext;
  logic [ATT_W-1:0]      attempt, attemptNext;
  logic [TO_W-1:0]       toCnt, toCntNext;
  logic [GAP_W-1:0]      gapCnt, gapCntNext;
  logic [I2C_WORD_W-1:0] dataReg, dataNext;
  logic                  goReg, goNext;
  logic                  busyReg, busyNext;
  logic [NUM_REQ-1:0]    gntReg, gntNext;
  logic [NUM_REQ-1:0]    doneReg, doneNext;
  logic [NUM_REQ-1:0]    errReg, errNext;

  logic                  tick;
  logic                  pickValid;
  logic [IDX_W-1:0]      pickIdx;
  logic [IDX_W-1:0]      candIdx;

  function automatic logic [IDX_W-1:0] wrapIdx(input int v);
    int w;
    w = (v >= NUM_REQ) ? v - NUM_REQ : v;
    return w[IDX_W-1:0];
  endfunction

  i2c_tick_gen #(.CLK_DIV(CLK_DIV)) uTickGen (
    .iCLK     (iCLK),
    .iRST     (iRST),
    .oI2C_CLK (bus.oI2C_CLK),
    .oTick    (tick)
  );

  // First pending request at or above the round-robin pointer, with wrap
  always_comb begin
    pickValid = 1'b0;
    pickIdx   = '0;
    candIdx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      candIdx = wrapIdx(int'(rrPtr) + k);
      if (!pickValid && bus.iREQ[candIdx]) begin
        pickValid = 1'b1;
        pickIdx   = candIdx;
      end
    end
  end

  // Next-state and output decode; everything visible to the controller moves only on ticks
  always_comb begin
    stateNext   = state;
    rrPtrNext   = rrPtr;
    ownerNext   = owner;
    attemptNext = attempt;
    toCntNext   = toCnt;
    gapCntNext  = gapCnt;
    dataNext    = dataReg;
    goNext      = goReg;
    busyNext    = busyReg;
    gntNext     = '0;
    doneNext    = '0;
    errNext     = '0;
    if (state == FAIL) begin
      // Resolved immediately so a final failure reports at the very next tick
      if (attempt < ATT_W'(MAX_RETRY)) begin
        attemptNext = attempt + 1'b1;
        gapCntNext  = '0;
        stateNext   = GAP;
      end else begin
        stateNext   = RESP_ERR;
      end
    end else if (tick) begin
      case (state)
        IDLE: begin
          if (pickValid) begin
            dataNext          = bus.iDATA[int'(pickIdx)*I2C_WORD_W +: I2C_WORD_W];
            gntNext[pickIdx]  = 1'b1;
            busyNext          = 1'b1;
            ownerNext         = pickIdx;
            rrPtrNext         = wrapIdx(int'(pickIdx) + 1);
            attemptNext       = ATT_W'(1);
            stateNext         = ISSUE;
          end
        end
        ISSUE: begin
          goNext    = 1'b1;
          toCntNext = '0;
          stateNext = WAIT;
        end
        WAIT: begin
          if (bus.iI2C_END) begin
            goNext    = 1'b0;
            stateNext = (bus.iI2C_ACK == ACK_OK) ? RESP_OK : FAIL;
          end else begin
            toCntNext = toCnt + 1'b1;
            if (toCnt == TO_W'(TIMEOUT - 1)) begin
              goNext    = 1'b0;
              stateNext = FAIL;
            end
          end
        end
        GAP: begin
          if (gapCnt == GAP_W'(RETRY_GAP - 1)) stateNext = ISSUE;
          else                                 gapCntNext = gapCnt + 1'b1;
        end
        RESP_OK: begin
          doneNext[owner] = 1'b1;
          busyNext        = 1'b0;
          stateNext       = IDLE;
        end
        RESP_ERR: begin
          errNext[owner] = 1'b1;
          busyNext       = 1'b0;
          stateNext      = IDLE;
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  // State and output registers; pulse registers fall back to zero one cycle after a tick
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state   <= IDLE;
      rrPtr   <= '0;
      owner   <= '0;
      attempt <= '0;
      toCnt   <= '0;
      gapCnt  <= '0;
      dataReg <= '0;
      goReg   <= 1'b0;
      busyReg <= 1'b0;
      gntReg  <= '0;
      doneReg <= '0;
      errReg  <= '0;
    end else begin
      state   <= stateNext;
      rrPtr   <= rrPtrNext;
      owner   <= ownerNext;
      attempt <= attemptNext;
      toCnt   <= toCntNext;
      gapCnt  <= gapCntNext;
      dataReg <= dataNext;
      goReg   <= goNext;
      busyReg <= busyNext;
      gntReg  <= gntNext;
      doneReg <= doneNext;
      errReg  <= errNext;
    end
  end

  assign bus.oGNT      = gntReg;
  assign bus.oDONE     = doneReg;
  assign bus.oERR      = errReg;
  assign bus.oBUSY     = busyReg;
  assign bus.oI2C_DATA = dataReg;
  assign bus.oI2C_GO   = goReg;

endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// Bench for i2c_cmd_arbiter: behavioural controller, event log and round-robin reference.
module tb_i2c_cmd_arbiter;
  import i2c_cfg_pkg::*;

  localparam int NUM_REQ   = 3;
  localparam int CLK_DIV   = 4;
  localparam int MAX_RETRY = 3;
  localparam int RETRY_GAP = 4;
  localparam int TIMEOUT   = 64;
  localparam int TICK_CYC  = 2 * CLK_DIV;

  logic iCLK = 1'b0;
  logic iRST = 1'b1;

  always #5 iCLK = ~iCLK;

  i2c_cmd_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  i2c_cmd_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .CLK_DIV   (CLK_DIV),
    .MAX_RETRY (MAX_RETRY),
    .RETRY_GAP (RETRY_GAP),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .iCLK (iCLK),
    .iRST (iRST),
    .bus  (bus)
  );

  int nAsserts = 0;
  int nFails   = 0;

  // Controller behaviour knobs, written by the stimulus
  int ctlDelay = 10;               // ticks from GO to END, -1 = never
  int nackReq[NUM_REQ];            // leading NACKed attempts per requester
  logic [23:0] reqData[NUM_REQ];
  int mPtr = 0;                    // reference round-robin pointer

  // Event log, written only by the monitor
  int tickNo = 0;
  int gntQ[$], gntTickQ[$], gntBusyQ[$];
  logic [23:0] gntDataQ[$], goDataQ[$];
  int goRiseQ[$], goFallQ[$], endTickQ[$];
  int doneQ[$], doneTickQ[$], errQ[$], errTickQ[$];
  logic prevClk = 1'b0, prevGo = 1'b0;
  int lastOwner = 0, attemptIdx = 0, ctlCnt = 0;
  bit ctlActive = 1'b0;

  // Monitor plus behavioural byte-level controller
  always @(negedge iCLK) begin
    bit rose;
    rose = bus.oI2C_CLK && !prevClk;
    prevClk = bus.oI2C_CLK;
    if (rose) tickNo++;
    if (iRST) begin
      bus.iI2C_END = 1'b0;
      bus.iI2C_ACK = 1'b0;
      ctlActive = 1'b0;
    end else if (rose) begin
      if (bus.iI2C_END && !bus.oI2C_GO) bus.iI2C_END = 1'b0;
      else if (ctlActive) begin
        ctlCnt++;
        if (ctlDelay >= 0 && ctlCnt >= ctlDelay) begin
          bus.iI2C_END = 1'b1;
          bus.iI2C_ACK = (attemptIdx <= nackReq[lastOwner]);
          ctlActive = 1'b0;
          endTickQ.push_back(tickNo);
        end
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (bus.oGNT[i]) begin
        gntQ.push_back(i); gntTickQ.push_back(tickNo);
        gntDataQ.push_back(bus.oI2C_DATA); gntBusyQ.push_back(int'(bus.oBUSY));
        lastOwner = i; attemptIdx = 0;
      end
      if (bus.oDONE[i]) begin doneQ.push_back(i); doneTickQ.push_back(tickNo); end
      if (bus.oERR[i])  begin errQ.push_back(i);  errTickQ.push_back(tickNo);  end
    end
    if (bus.oI2C_GO && !prevGo) begin
      goRiseQ.push_back(tickNo); goDataQ.push_back(bus.oI2C_DATA);
      attemptIdx++; ctlCnt = 0; ctlActive = 1'b1;
    end
    if (!bus.oI2C_GO && prevGo) goFallQ.push_back(tickNo);
    prevGo = bus.oI2C_GO;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int rrPick(input logic [2:0] m, input int p);
    for (int k = 0; k < NUM_REQ; k++) begin
      int c;
      c = (p + k) % NUM_REQ;
      if (m[c]) return c;
    end
    return -1;
  endfunction

  // One cycle; requesters withdraw as soon as they see their grant
  task automatic step();
    @(negedge iCLK);
    for (int i = 0; i < NUM_REQ; i++)
      if (bus.oGNT[i]) bus.iREQ[i] = 1'b0;
  endtask

  task automatic raise(input logic [2:0] m);
    for (int i = 0; i < NUM_REQ; i++)
      if (m[i]) bus.iDATA[i*24 +: 24] = reqData[i];
    bus.iREQ = bus.iREQ | m;
  endtask

  task automatic waitFor(input string tag, input int target, input int maxCycles);
    int c = 0;
    while ((doneQ.size() + errQ.size()) < target && c < maxCycles) begin
      step();
      c++;
    end
    chk(tag, 32'(doneQ.size() + errQ.size()), 32'(target));
    repeat (2) step();
  endtask

  task automatic resetDut();
    iRST = 1'b1;
    bus.iREQ = '0;
    repeat (3) step();
    iRST = 1'b0;
    mPtr = 0;
    step();
  endtask

  // Batch of simultaneous requests, all expected to complete; order from the reference pointer
  task automatic runRound(input string tag, input logic [2:0] m);
    int expQ[$];
    logic [2:0] left;
    int bg, bd, be, c;
    left = m; bg = gntQ.size(); bd = doneQ.size(); be = errQ.size();
    while (left != 3'b000) begin
      c = rrPick(left, mPtr);
      expQ.push_back(c);
      left = left & ~(3'b001 << c);
      mPtr = (c + 1) % NUM_REQ;
    end
    raise(m);
    waitFor({tag, "_events"}, doneQ.size() + errQ.size() + expQ.size(), 400 * TICK_CYC);
    chk({tag, "_ngnt"}, 32'(gntQ.size() - bg), 32'(expQ.size()));
    foreach (expQ[k]) begin
      if (bg + k < gntQ.size()) begin
        chk({tag, "_order"}, 32'(gntQ[bg+k]), 32'(expQ[k]));
        chk({tag, "_data"}, 32'(gntDataQ[bg+k]), 32'(reqData[expQ[k]]));
      end
      if (bd + k < doneQ.size()) chk({tag, "_done"}, 32'(doneQ[bd+k]), 32'(expQ[k]));
    end
    chk({tag, "_noerr"}, 32'(errQ.size()), 32'(be));
  endtask

  initial begin
    #(2_000_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bg, br, bf, be, bd, bt, c;
    int expIdx;
    bus.iREQ = '0;
    bus.iDATA = '0;
    for (int i = 0; i < NUM_REQ; i++) begin nackReq[i] = 0; reqData[i] = '0; end

    // Reset values while reset is held
    repeat (3) step();
    chk("rst_clk",  32'(bus.oI2C_CLK),  32'd0);
    chk("rst_go",   32'(bus.oI2C_GO),   32'd0);
    chk("rst_data", 32'(bus.oI2C_DATA), 32'd0);
    chk("rst_gnt",  32'(bus.oGNT),      32'd0);
    chk("rst_done", 32'(bus.oDONE),     32'd0);
    chk("rst_err",  32'(bus.oERR),      32'd0);
    chk("rst_busy", 32'(bus.oBUSY),     32'd0);
    iRST = 1'b0;
    step();

    // Single audio-codec write, ACKed 10 ticks after GO
    reqData[0] = {AUDIO_ADDR, 16'h0079};
    ctlDelay = 10;
    bg = gntQ.size(); br = goRiseQ.size(); bd = doneQ.size(); be = errQ.size(); bt = endTickQ.size();
    raise(3'b001);
    mPtr = 1;
    waitFor("single_events", doneQ.size() + errQ.size() + 1, 100 * TICK_CYC);
    chk("single_ngnt", 32'(gntQ.size() - bg), 32'd1);
    chk("single_gntidx", 32'(gntQ[bg]), 32'd0);
    chk("single_data", 32'(gntDataQ[bg]), 32'h340079);
    chk("single_busy_at_gnt", 32'(gntBusyQ[bg]), 32'd1);
    chk("single_ngo", 32'(goRiseQ.size() - br), 32'd1);
    chk("single_go_lat", 32'(goRiseQ[br]), 32'(gntTickQ[bg] + 1));
    chk("single_go_data", 32'(goDataQ[br]), 32'h340079);
    chk("single_end_delay", 32'(endTickQ[bt] - goRiseQ[br]), 32'd10);
    chk("single_ndone", 32'(doneQ.size() - bd), 32'd1);
    chk("single_doneidx", 32'(doneQ[bd]), 32'd0);
    chk("single_done_lat", 32'(doneTickQ[bd]), 32'(endTickQ[bt] + 2));
    chk("single_noerr", 32'(errQ.size()), 32'(be));
    chk("single_busy_after", 32'(bus.oBUSY), 32'd0);

    // Round robin from a fresh pointer: all three, then 1 and 0
    resetDut();
    reqData[0] = 24'h340A1B; reqData[1] = 24'h401122; reqData[2] = 24'h34C3D4;
    ctlDelay = 4;
    runRound("rr_all", 3'b111);
    runRound("rr_pair", 3'b011);

    // Two NACKs then ACK on requester 2
    nackReq[2] = 2;
    ctlDelay = 3;
    reqData[2] = {VIDEO_ADDR, 16'h0203};
    br = goRiseQ.size(); bf = goFallQ.size(); bd = doneQ.size(); be = errQ.size(); bg = gntQ.size();
    expIdx = rrPick(3'b100, mPtr);
    mPtr = (expIdx + 1) % NUM_REQ;
    raise(3'b100);
    waitFor("retry_events", doneQ.size() + errQ.size() + 1, 200 * TICK_CYC);
    chk("retry_gnt", 32'(gntQ[bg]), 32'(expIdx));
    chk("retry_ngo", 32'(goRiseQ.size() - br), 32'(MAX_RETRY));
    for (int k = 0; k < 3; k++)
      if (br + k < goDataQ.size()) chk("retry_go_data", 32'(goDataQ[br+k]), 32'h400203);
    for (int k = 0; k < 2; k++)
      if (br + k + 1 < goRiseQ.size() && bf + k < goFallQ.size())
        chk("retry_gap", 32'(goRiseQ[br+k+1] - goFallQ[bf+k] - 1), 32'(RETRY_GAP));
    chk("retry_ndone", 32'(doneQ.size() - bd), 32'd1);
    chk("retry_doneidx", 32'(doneQ[bd]), 32'd2);
    chk("retry_noerr", 32'(errQ.size()), 32'(be));
    nackReq[2] = 0;

    // Persistent NACK on requester 0 with requester 1 queued behind it
    nackReq[0] = 15;
    reqData[0] = 24'h34_0E0F; reqData[1] = 24'h40_0A0B;
    br = goRiseQ.size(); bf = goFallQ.size(); bd = doneQ.size(); be = errQ.size(); bg = gntQ.size();
    expIdx = rrPick(3'b011, mPtr);
    raise(3'b011);
    waitFor("nack_events", doneQ.size() + errQ.size() + 2, 300 * TICK_CYC);
    chk("nack_first_gnt", 32'(gntQ[bg]), 32'(expIdx));
    chk("nack_second_gnt", 32'(gntQ[bg+1]), 32'(1 - expIdx));
    mPtr = (1 - expIdx + 1) % NUM_REQ;
    chk("nack_ngo", 32'(goRiseQ.size() - br), 32'(MAX_RETRY + 1));
    chk("nack_nerr", 32'(errQ.size() - be), 32'd1);
    chk("nack_erridx", 32'(errQ[be]), 32'd0);
    chk("nack_err_lat", 32'(errTickQ[be]), 32'(goFallQ[bf+2] + 1));
    chk("nack_next_go", 32'(goRiseQ[br+3]), 32'(errTickQ[be] + 2));
    chk("nack_ndone", 32'(doneQ.size() - bd), 32'd1);
    chk("nack_doneidx", 32'(doneQ[bd]), 32'd1);
    nackReq[0] = 0;

    // END never comes: three timed-out attempts on requester 1
    ctlDelay = -1;
    br = goRiseQ.size(); bf = goFallQ.size(); bd = doneQ.size(); be = errQ.size();
    mPtr = 2;
    raise(3'b010);
    waitFor("tmo_events", doneQ.size() + errQ.size() + 1, 3 * (TIMEOUT + 20) * TICK_CYC);
    chk("tmo_ngo", 32'(goRiseQ.size() - br), 32'(MAX_RETRY));
    for (int k = 0; k < 3; k++)
      if (bf + k < goFallQ.size()) chk("tmo_go_len", 32'(goFallQ[bf+k] - goRiseQ[br+k]), 32'(TIMEOUT));
    chk("tmo_nerr", 32'(errQ.size() - be), 32'd1);
    chk("tmo_erridx", 32'(errQ[be]), 32'd1);
    chk("tmo_err_lat", 32'(errTickQ[be]), 32'(goFallQ[bf+2] + 1));
    chk("tmo_nodone", 32'(doneQ.size()), 32'(bd));

    // Randomized batches against the round-robin reference
    for (int r = 0; r < 8; r++) begin
      logic [2:0] m;
      ctlDelay = int'($urandom_range(1, 12));
      for (int i = 0; i < NUM_REQ; i++) begin
        reqData[i] = 24'($urandom);
        nackReq[i] = int'($urandom_range(0, 1));
      end
      m = 3'($urandom_range(1, 7));
      runRound("rand", m);
    end
    for (int i = 0; i < NUM_REQ; i++) nackReq[i] = 0;

    // Reset while waiting for END; pointer must return to 0
    ctlDelay = -1;
    reqData[1] = 24'h40_1234;
    raise(3'b010);
    c = 0;
    while (!bus.oI2C_GO && c < 50 * TICK_CYC) begin step(); c++; end
    chk("rst_go_seen", 32'(bus.oI2C_GO), 32'd1);
    repeat (3 * TICK_CYC) step();
    bd = doneQ.size(); be = errQ.size();
    #2 iRST = 1'b1;
    #1;
    chk("arst_go",   32'(bus.oI2C_GO),  32'd0);
    chk("arst_clk",  32'(bus.oI2C_CLK), 32'd0);
    chk("arst_busy", 32'(bus.oBUSY),    32'd0);
    repeat (2) step();
    iRST = 1'b0;
    mPtr = 0;
    repeat (20 * TICK_CYC) step();
    chk("arst_nodone", 32'(doneQ.size()), 32'(bd));
    chk("arst_noerr",  32'(errQ.size()),  32'(be));
    ctlDelay = 5;
    reqData[1] = 24'h34_0506; reqData[2] = 24'h40_0708;
    runRound("post_rst", 3'b110);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
